systolic_feeder_2x2: RTL

Upstream operand scheduler for the 2x2 systolic multiply array. Accepts one pair of 2x2 matrices A and B through a valid/ready handshake. Issues them to the array as diagonally skewed row/column beats, each qualified by a one-cycle load pulse, followed by a zero flush beat. Then waits for the array's done before accepting the next matrix pair.

---
 rtl/systolic_feeder_2x2_pkg.sv | 30 +++
 rtl/systolic_feeder_2x2_if.sv | 36 +++
 rtl/systolic_feeder_2x2_beat_mux.sv | 47 ++++
 rtl/systolic_feeder_2x2.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_2x2_pkg.sv
// ----------------------------------------------------------------------------
// systolic_feeder_2x2_pkg : shared state encoding and operand index constants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package systolic_feeder_2x2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_GAP       = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

  localparam int NUM_BEATS = 4;

  // Element slots within the packed matrix words, element 00 in the LSBs
  localparam int A00_IDX = 0;
  localparam int A01_IDX = 1;
  localparam int A10_IDX = 2;
  localparam int A11_IDX = 3;
  localparam int B00_IDX = 0;
  localparam int B01_IDX = 1;
  localparam int B10_IDX = 2;
  localparam int B11_IDX = 3;

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_2x2_if.sv
// ----------------------------------------------------------------------------
// systolic_feeder_2x2_if : upstream handshake and array-side operand bundle
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface systolic_feeder_2x2_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DATA_W-1:0]   a_flat;
  logic [4*DATA_W-1:0]   b_flat;
  logic                  load_out;
  logic [DATA_W-1:0]     row0_out;
  logic [DATA_W-1:0]     row1_out;
  logic [DATA_W-1:0]     col0_out;
  logic [DATA_W-1:0]     col1_out;
  logic                  arr_done;
  logic                  mat_done;
  logic                  timeout_err;

  modport slave (
    input  in_valid, a_flat, b_flat, arr_done,
    output in_ready, load_out, row0_out, row1_out, col0_out, col1_out,
           mat_done, timeout_err
  );

  modport master (
    output in_valid, a_flat, b_flat, arr_done,
    input  in_ready, load_out, row0_out, row1_out, col0_out, col1_out,
           mat_done, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/systolic_feeder_2x2_beat_mux.sv
// ----------------------------------------------------------------------------
// feeder_beat_mux : maps beat index and captured A/B to skewed operands
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module feeder_beat_mux
  import systolic_feeder_2x2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]            beat_i,
  input  logic [4*DATA_W-1:0]   a_i,
  input  logic [4*DATA_W-1:0]   b_i,
  output logic [DATA_W-1:0]     row0_o,
  output logic [DATA_W-1:0]     row1_o,
  output logic [DATA_W-1:0]     col0_o,
  output logic [DATA_W-1:0]     col1_o
);

  always_comb begin
    row0_o = '0;
    row1_o = '0;
    col0_o = '0;
    col1_o = '0;
    case (beat_i)
      2'd0: begin
        row0_o = a_i[A00_IDX*DATA_W +: DATA_W];
        col0_o = b_i[B00_IDX*DATA_W +: DATA_W];
      end
      2'd1: begin
        row0_o = a_i[A01_IDX*DATA_W +: DATA_W];
        row1_o = a_i[A10_IDX*DATA_W +: DATA_W];
        col0_o = b_i[B10_IDX*DATA_W +: DATA_W];
        col1_o = b_i[B01_IDX*DATA_W +: DATA_W];
      end
      2'd2: begin
        row1_o = a_i[A11_IDX*DATA_W +: DATA_W];
        col1_o = b_i[B11_IDX*DATA_W +: DATA_W];
      end
      default: ;  // flush beat stays all zero
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/systolic_feeder_2x2.sv
// ----------------------------------------------------------------------------
// systolic_feeder_2x2 : skewed operand scheduler for the 2x2 systolic array
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module systolic_feeder_2x2
  import systolic_feeder_2x2_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BEAT_PERIOD  = 21,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_feeder_2x2_if.slave bus
);

  localparam logic [7:0]  GAP_LAST   = 8'((BEAT_PERIOD > 1) ? BEAT_PERIOD - 2 : 0);
  localparam logic [15:0] TIMER_LAST = 16'(DONE_TIMEOUT - 1);
  localparam logic [1:0]  BEAT_LAST  = 2'(NUM_BEATS - 1);

  state_e                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [7:0]            gap_q, gap_d;
  logic [15:0]           timer_q, timer_d;
  logic [4*DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                  load_q, load_d;
  logic [DATA_W-1:0]     row0_q, row0_d, row1_q, row1_d;
  logic [DATA_W-1:0]     col0_q, col0_d, col1_q, col1_d;
  logic                  mat_done_q, mat_done_d;
  logic                  timeout_q, timeout_d;
  logic                  in_ready_q, in_ready_d;
  logic [DATA_W-1:0]     mux_row0, mux_row1, mux_col0, mux_col1;

  logic accept, done_hit, tmo_hit;

  assign accept   = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
  // arr_done has priority over an expiring timer
  assign done_hit = (state_q == ST_WAIT_DONE) && bus.arr_done;
  assign tmo_hit  = (state_q == ST_WAIT_DONE) && !bus.arr_done && (timer_q == TIMER_LAST);

  feeder_beat_mux #(.DATA_W(DATA_W)) u_beat_mux (
    .beat_i (beat_q),
    .a_i    (a_q),
    .b_i    (b_q),
    .row0_o (mux_row0),
    .row1_o (mux_row1),
    .col0_o (mux_col0),
    .col1_o (mux_col1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      gap_q      <= '0;
      timer_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      load_q     <= 1'b0;
      row0_q     <= '0;
      row1_q     <= '0;
      col0_q     <= '0;
      col1_q     <= '0;
      mat_done_q <= 1'b0;
      timeout_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      timer_q    <= timer_d;
      a_q        <= a_d;
      b_q        <= b_d;
      load_q     <= load_d;
      row0_q     <= row0_d;
      row1_q     <= row1_d;
      col0_q     <= col0_d;
      col1_q     <= col1_d;
      mat_done_q <= mat_done_d;
      timeout_q  <= timeout_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    timer_d = timer_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          a_d     = bus.a_flat;
          b_d     = bus.b_flat;
          beat_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        beat_d  = beat_q + 2'd1;
        gap_d   = '0;
        timer_d = '0;
        if (beat_q == BEAT_LAST)    state_d = ST_WAIT_DONE;
        else if (BEAT_PERIOD == 1)  state_d = ST_ISSUE;
        else                        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_ISSUE;
        else                   gap_d   = gap_q + 8'd1;
      end
      ST_WAIT_DONE: begin
        if (done_hit || tmo_hit) begin
          state_d = ST_IDLE;
          a_d     = '0;
          b_d     = '0;
          beat_d  = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
    endcase
  end

  always_comb begin
    load_d     = 1'b0;
    row0_d     = row0_q;
    row1_d     = row1_q;
    col0_d     = col0_q;
    col1_d     = col1_q;
    mat_done_d = 1'b0;
    timeout_d  = 1'b0;
    in_ready_d = (state_q == ST_IDLE) && !accept;
    if (state_q == ST_ISSUE) begin
      load_d = 1'b1;
      row0_d = mux_row0;
      row1_d = mux_row1;
      col0_d = mux_col0;
      col1_d = mux_col1;
    end else if (done_hit || tmo_hit) begin
      row0_d     = '0;
      row1_d     = '0;
      col0_d     = '0;
      col1_d     = '0;
      mat_done_d = done_hit;
      timeout_d  = tmo_hit;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.load_out    = load_q;
  assign bus.row0_out    = row0_q;
  assign bus.row1_out    = row1_q;
  assign bus.col0_out    = col0_q;
  assign bus.col1_out    = col1_q;
  assign bus.mat_done    = mat_done_q;
  assign bus.timeout_err = timeout_q;

endmodule

`default_nettype wire
